// File: rtl/merge_rr_ehb.sv
// rtl/merge_rr_ehb.sv - N-input data merge, round-robin or fixed-priority grant, one-slot registered output
module merge_rr_ehb #(
  parameter int INPUTS      = 2,
  parameter int DATA_TYPE   = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int INDEX_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUTS*DATA_TYPE-1:0] ins,
  input  logic [INPUTS-1:0]           ins_valid,
  output logic [INPUTS-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]        outs,
  output logic [INDEX_WIDTH-1:0]      outs_index,
  output logic                        outs_valid,
  input  logic                        outs_ready
);

  logic                   full;
  logic [DATA_TYPE-1:0]   data_reg;
  logic [INDEX_WIDTH-1:0] idx_reg;
  logic [INDEX_WIDTH-1:0] ptr;

  logic                   load;
  logic                   grant_valid;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic [DATA_TYPE-1:0]   grant_data;
  int                     best_off;
  int                     off;

  assign load = !full || outs_ready;

  // Each valid channel's distance from ptr in scan order; the smallest distance wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_off    = INPUTS;
    off         = 0;
    for (int i = 0; i < INPUTS; i++) begin
      if (ROUND_ROBIN != 0) begin
        off = (i + INPUTS - int'(ptr)) % INPUTS;
      end else begin
        off = i;
      end
      if (ins_valid[i] && (off < best_off)) begin
        best_off    = off;
        grant_valid = 1'b1;
        grant_idx   = INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    ins_ready  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_idx == INDEX_WIDTH'(i)) begin
        grant_data   = ins[i*DATA_TYPE +: DATA_TYPE];
        ins_ready[i] = load && grant_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      data_reg <= '0;
      idx_reg  <= '0;
      ptr      <= '0;
    end else if (load && grant_valid) begin
      full     <= 1'b1;
      data_reg <= grant_data;
      idx_reg  <= grant_idx;
      // Pointer moves only on an accepted grant, so stalls never shift priority.
      if (ROUND_ROBIN != 0) begin
        if (grant_idx == INDEX_WIDTH'(INPUTS - 1)) begin
          ptr <= '0;
        end else begin
          ptr <= grant_idx + INDEX_WIDTH'(1);
        end
      end
    end else if (outs_ready) begin
      full <= 1'b0;
    end
  end

  assign outs       = data_reg;
  assign outs_index = idx_reg;
  assign outs_valid = full;

endmodule

// File: tb/tb_merge_rr_ehb.sv
// tb/tb_merge_rr_ehb.sv - directed vectors for merge_rr_ehb in round-robin and fixed-priority builds
module tb_merge_rr_ehb;

  logic clk;
  logic rst;

  logic [23:0] rr_ins;
  logic [2:0]  rr_valid;
  logic [2:0]  rr_ready;
  logic [7:0]  rr_outs;
  logic [1:0]  rr_idx;
  logic        rr_ovalid;
  logic        rr_oready;

  logic [23:0] fp_ins;
  logic [2:0]  fp_valid;
  logic [2:0]  fp_ready;
  logic [7:0]  fp_outs;
  logic [1:0]  fp_idx;
  logic        fp_ovalid;
  logic        fp_oready;

  logic [31:0] q_ins;
  logic [3:0]  q_valid;
  logic [3:0]  q_ready;
  logic [7:0]  q_outs;
  logic [1:0]  q_idx;
  logic        q_ovalid;
  logic        q_oready;

  int vectors;
  int miscompares;

  merge_rr_ehb #(.INPUTS(3), .DATA_TYPE(8), .ROUND_ROBIN(1)) u_rr3 (
    .clk(clk), .rst(rst), .ins(rr_ins), .ins_valid(rr_valid), .ins_ready(rr_ready),
    .outs(rr_outs), .outs_index(rr_idx), .outs_valid(rr_ovalid), .outs_ready(rr_oready)
  );

  merge_rr_ehb #(.INPUTS(3), .DATA_TYPE(8), .ROUND_ROBIN(0)) u_fp3 (
    .clk(clk), .rst(rst), .ins(fp_ins), .ins_valid(fp_valid), .ins_ready(fp_ready),
    .outs(fp_outs), .outs_index(fp_idx), .outs_valid(fp_ovalid), .outs_ready(fp_oready)
  );

  merge_rr_ehb #(.INPUTS(4), .DATA_TYPE(8), .ROUND_ROBIN(1)) u_rr4 (
    .clk(clk), .rst(rst), .ins(q_ins), .ins_valid(q_valid), .ins_ready(q_ready),
    .outs(q_outs), .outs_index(q_idx), .outs_valid(q_ovalid), .outs_ready(q_oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    rst       = 1'b1;
    rr_ins    = {8'h0C, 8'h0B, 8'h0A};
    rr_valid  = 3'b111;
    rr_oready = 1'b1;
    fp_ins    = {8'h2C, 8'h2B, 8'h2A};
    fp_valid  = 3'b111;
    fp_oready = 1'b1;
    q_ins     = {8'h43, 8'h42, 8'h41, 8'h40};
    q_valid   = 4'b1111;
    q_oready  = 1'b1;

    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_rr_valid", 32'(rr_ovalid), 32'd0);
      check("rst_fp_valid", 32'(fp_ovalid), 32'd0);
      check("rst_q_valid", 32'(q_ovalid), 32'd0);
    end
    check("rst_rr_outs", 32'(rr_outs), 32'd0);
    check("rst_rr_idx", 32'(rr_idx), 32'd0);
    check("rst_q_outs", 32'(q_outs), 32'd0);

    rst      = 1'b0;
    fp_valid = 3'b101;
    q_valid  = 4'b0000;

    // Round-robin rotation 0,1,2,... alongside fixed priority always choosing 0.
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_valid", 32'(rr_ovalid), 32'd1);
      check("rr_idx", 32'(rr_idx), 32'(k % 3));
      check("rr_data", 32'(rr_outs), 32'(8'h0A + k % 3));
      check("fp_idx", 32'(fp_idx), 32'd0);
      check("fp_data", 32'(fp_outs), 32'h2A);
      check("fp_ready2", 32'(fp_ready[2]), 32'd0);
      check("fp_ready0", 32'(fp_ready[0]), 32'd1);
    end
    fp_valid = 3'b000;

    // Backpressure: 0x55 from input 1 held while the consumer stalls.
    rr_ins   = {8'h00, 8'h55, 8'h11};
    rr_valid = 3'b010;
    step();
    check("bp_load_data", 32'(rr_outs), 32'h55);
    check("bp_load_idx", 32'(rr_idx), 32'd1);
    rr_oready = 1'b0;
    rr_valid  = 3'b001;
    for (int c = 0; c < 4; c++) begin
      step();
      check("bp_hold_data", 32'(rr_outs), 32'h55);
      check("bp_hold_idx", 32'(rr_idx), 32'd1);
      check("bp_hold_valid", 32'(rr_ovalid), 32'd1);
      check("bp_hold_ready", 32'(rr_ready), 32'd0);
    end
    rr_oready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_ready), 32'b001);
    step();
    check("bp_nobubble_valid", 32'(rr_ovalid), 32'd1);
    check("bp_nobubble_data", 32'(rr_outs), 32'h11);
    check("bp_nobubble_idx", 32'(rr_idx), 32'd0);
    rr_valid = 3'b000;
    step();
    check("bp_drain_valid", 32'(rr_ovalid), 32'd0);

    // Pointer wraps after input 3 and holds over idle cycles.
    q_valid = 4'b1000;
    step();
    check("ph_wrap_idx", 32'(q_idx), 32'd3);
    check("ph_wrap_data", 32'(q_outs), 32'h43);
    q_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      check("ph_idle_valid", 32'(q_ovalid), 32'd0);
    end
    q_valid = 4'b1010;
    step();
    check("ph_first_idx", 32'(q_idx), 32'd1);
    check("ph_first_data", 32'(q_outs), 32'h41);
    step();
    check("ph_second_idx", 32'(q_idx), 32'd3);

    // Mid-operation reset with a stalled full slot; ptr would otherwise be 3.
    q_valid = 4'b0100;
    step();
    check("mr_load_idx", 32'(q_idx), 32'd2);
    q_oready = 1'b0;
    q_valid  = 4'b0000;
    step();
    check("mr_stall_valid", 32'(q_ovalid), 32'd1);
    rst = 1'b1;
    step();
    check("mr_rst_valid", 32'(q_ovalid), 32'd0);
    check("mr_rst_outs", 32'(q_outs), 32'd0);
    rst      = 1'b0;
    q_oready = 1'b1;
    q_valid  = 4'b1010;
    step();
    check("mr_next_idx", 32'(q_idx), 32'd1);
    check("mr_next_data", 32'(q_outs), 32'h41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/merge_rr_ehb.md
# merge_rr_ehb

Parametrised N-input data merge with a selectable round-robin or fixed-priority arbiter and a registered one-slot output buffer. Each cycle it grants at most one valid input, captures its data and index into an output register, and presents them on a single elastic output channel. It is the buffered, fair successor to the unbuffered dataless merge. It is placed where several dataflow producers feed one consumer and a combinational valid path through the merge would break timing.

## Interface
Parameters:
- INPUTS, default 2: number of input channels, 1 or more.
- DATA_TYPE, default 32: data width per channel, 1 or more.
- ROUND_ROBIN, default 1: 1 selects rotating priority; 0 selects fixed priority, where the lowest index wins.
- INDEX_WIDTH, default max(1, clog2(INPUTS)): width of outs_index.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset. One clock domain only; reset polarity and synchronicity are fixed.
- ins, input, INPUTS*DATA_TYPE: input data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_valid, input, INPUTS: per-channel valid.
- ins_ready, output, INPUTS: per-channel ready; at most one bit is high.
- outs, output, DATA_TYPE: registered output data.
- outs_index, output, INDEX_WIDTH: registered index of the channel that supplied outs.
- outs_valid, output, 1: registered output valid.
- outs_ready, input, 1: consumer ready.

## Operation
- State consists of four items:
  - full: the output slot is occupied; it drives outs_valid.
  - data_reg, which drives outs.
  - idx_reg, which drives outs_index.
  - ptr: round-robin pointer, 0..INPUTS-1.
- load = !full || outs_ready. The slot can accept when it is empty or is draining in the same cycle.
- Grant, which is combinational:
  - ROUND_ROBIN=1: the first i with ins_valid[i] high, scanning ptr, ptr+1, …, INPUTS-1, 0, …, ptr-1.
  - ROUND_ROBIN=0: the lowest i with ins_valid[i] high.
  - If no input is valid, there is no grant.
- ins_ready[i] = load && grant==i. Every non-granted channel sees ready low, including channels that are valid.
- Transfer on input i: ins_valid[i] && ins_ready[i]. On a transfer:
  - data_reg and idx_reg are loaded with channel i's data and index i.
  - full is set to 1.
  - When ROUND_ROBIN=1, ptr becomes (i+1) mod INPUTS. At i = INPUTS-1, ptr wraps to 0.
- Output handshake: outs_valid && outs_ready. If no input transfers in the same cycle, full is cleared.
- Simultaneous output handshake and input transfer: the slot is replaced, full stays 1, and there is no bubble.
- When no transfer happens, ptr holds its value. The pointer only advances on an accepted grant, so an idle or stalled cycle never shifts priority.
- While full && !outs_ready: outs, outs_index and outs_valid are held stable, and every ins_ready bit is 0.
- INPUTS=1: ptr is constant 0, outs_index is constant 0, and the block behaves as a one-slot pipeline register.
- Reset, synchronous on rst=1 at a clock edge:
  - full=0, so outs_valid=0.
  - data_reg=0, so outs=0.
  - idx_reg=0 and ptr=0.
  - The reset takes priority over any same-cycle transfer.
  - A slot that was mid-handshake is discarded.
  - ins_ready is 0 during the reset cycle only when full was 1 and outs_ready was 0; otherwise it follows the grant, but no capture occurs.

## Timing
- Latency is 1 cycle. Data granted at edge k appears on outs, with outs_valid high, after edge k.
- Throughput is 1 transfer per cycle while the consumer holds outs_ready=1.
- outs, outs_index and outs_valid are driven directly from flops, with no combinational path from any input.
- ins_ready has combinational paths from ins_valid, from outs_ready and from state. There is no path from ins or outs.
- There is no combinational dependency of ins_valid on ins_ready; producers must not wait for ready before asserting valid.
- Fairness (ROUND_ROBIN=1): with the consumer always ready, any continuously valid input is granted within INPUTS cycles.

## Test plan
- Reset / idle:
  - Stimulus: assert rst for 2 cycles with every ins_valid at 1.
  - Required response: outs_valid=0, outs=0, outs_index=0 after reset. No output transfer may be reported during reset.
- Round-robin:
  - Stimulus: INPUTS=3, ROUND_ROBIN=1, all inputs valid continuously with data 0xA, 0xB, 0xC, outs_ready=1.
  - Required response: outs_index sequence 0,1,2,0,1,2 with matching data, one item per cycle starting 1 cycle after reset release.
- Fixed priority:
  - Stimulus: ROUND_ROBIN=0, inputs 0 and 2 valid continuously.
  - Required response: every output has outs_index=0, and ins_ready[2] is never high.
- Backpressure:
  - Stimulus: input 1 sends 0x55, then outs_ready=0 for 4 cycles while input 0 is valid.
  - Required response: outs=0x55 and outs_index=1 held stable, ins_ready=0 throughout. When outs_ready rises, 0x55 drains and input 0's data is accepted in the same cycle, with no bubble.
- Pointer hold:
  - Stimulus: INPUTS=4, grant on input 3 (ptr wraps to 0), then 3 idle cycles, then inputs 1 and 3 valid.
  - Required response: input 1 is granted first.
- Mid-operation reset:
  - Stimulus: full slot with outs_ready=0, then assert rst for 1 cycle.
  - Required response: outs_valid=0 after the edge, and the next grant follows ptr=0.
